// File: rtl/cpu_trace_capture.sv
// rtl/cpu_trace_capture.sv - circular trace buffer for PC/Instr/Result with PC-match trigger
module cpu_trace_capture #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int POST  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     sample_valid,
  input  logic [W-1:0]             pc_in,
  input  logic [W-1:0]             instr_in,
  input  logic [W-1:0]             result_in,
  input  logic [W-1:0]             trig_pc,
  input  logic                     trig_pc_en,
  input  logic                     force_trig,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  input  logic [1:0]               rd_sel,
  output logic [W-1:0]             rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   trig_pos
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   trig_pos_q, trig_pos_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    rd_data_q, rd_data_d;

  logic [W-1:0]    pc_mem    [DEPTH];
  logic [W-1:0]    instr_mem [DEPTH];
  logic [W-1:0]    res_mem   [DEPTH];

  logic            trigger;
  logic            store;
  logic [CW-1:0]   count_inc;
  logic [AW-1:0]   rd_addr;

  assign trigger   = sample_valid & (force_trig | (trig_pc_en & (pc_in == trig_pc)));
  // arm discards a coincident sample, so it also blocks the store
  assign store     = sample_valid & ~arm & ((state_q == S_ARMED) | (state_q == S_CAPTURE));
  assign count_inc = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED:   if (trigger) state_d = (POST == 1) ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (sample_valid && remaining_q == CW'(1)) state_d = S_DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trig_pos_d  = trig_pos_q;
    remaining_d = remaining_q;
    if (arm) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      trig_pos_d = '0;
    end else if (store) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      count_d     = count_inc;
      remaining_d = (state_q == S_ARMED) ? CW'(POST - 1) : remaining_q - CW'(1);
      if (state_d == S_DONE) trig_pos_d = count_inc - CW'(POST);
    end
  end

  // Oldest sample sits count entries behind the write pointer
  always_comb begin
    rd_addr   = wr_ptr_q - count_q[AW-1:0] + rd_idx;
    rd_data_d = '0;
    if ({1'b0, rd_idx} < count_q) begin
      case (rd_sel)
        2'b00:   rd_data_d = pc_mem[rd_addr];
        2'b01:   rd_data_d = instr_mem[rd_addr];
        2'b10:   rd_data_d = res_mem[rd_addr];
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wr_ptr_q]    <= pc_in;
      instr_mem[wr_ptr_q] <= instr_in;
      res_mem[wr_ptr_q]   <= result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_pos_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trig_pos_q  <= trig_pos_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign trig_pos = trig_pos_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb/tb_cpu_trace_capture.sv - bench for cpu_trace_capture, POST=4 and POST=1 instances
module tb_cpu_trace_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, arm, sample_valid, trig_pc_en, force_trig;
  logic [31:0] pc_in, instr_in, result_in, trig_pc;
  logic [2:0]  rd_idx;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data4, rd_data1;
  logic        busy4, busy1, done4, done1;
  logic [3:0]  count4, count1, tpos4, tpos1;

  cpu_trace_capture #(.W(32), .DEPTH(8), .POST(4)) u_dut4 (
    .clk(clk), .reset(reset), .arm(arm), .sample_valid(sample_valid),
    .pc_in(pc_in), .instr_in(instr_in), .result_in(result_in),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .force_trig(force_trig),
    .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_data(rd_data4),
    .busy(busy4), .done(done4), .count(count4), .trig_pos(tpos4)
  );

  cpu_trace_capture #(.W(32), .DEPTH(8), .POST(1)) u_dut1 (
    .clk(clk), .reset(reset), .arm(arm), .sample_valid(sample_valid),
    .pc_in(pc_in), .instr_in(instr_in), .result_in(result_in),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .force_trig(force_trig),
    .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .count(count1), .trig_pos(tpos1)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] res;
  } samp_t;

  // Reference model: a sliding window of the last 8 stored samples plus a phase
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_DONE = 3;
  samp_t qa[$];
  samp_t qb[$];
  int    mode[2];
  int    left[2];
  int    tpos[2];

  function automatic int post_of(int p);
    return (p == 0) ? 4 : 1;
  endfunction

  function automatic int qsize(int p);
    return (p == 0) ? qa.size() : qb.size();
  endfunction

  function automatic samp_t qget(int p, int i);
    return (p == 0) ? qa[i] : qb[i];
  endfunction

  task automatic qpush(input int p, input samp_t s);
    if (p == 0) begin
      qa.push_back(s);
      if (qa.size() > 8) void'(qa.pop_front());
    end else begin
      qb.push_back(s);
      if (qb.size() > 8) void'(qb.pop_front());
    end
  endtask

  task automatic qclear(input int p);
    if (p == 0) qa.delete();
    else        qb.delete();
  endtask

  function automatic logic [31:0] model_read(int p, int idx, logic [1:0] sel);
    samp_t s;
    if (idx >= qsize(p)) return 32'h0;
    s = qget(p, idx);
    case (sel)
      2'b00:   return s.pc;
      2'b01:   return s.instr;
      2'b10:   return s.res;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input int p);
    samp_t s;
    bit    trig;
    s    = {pc_in, instr_in, result_in};
    trig = sample_valid && (force_trig || (trig_pc_en && pc_in == trig_pc));
    if (reset) begin
      mode[p] = M_IDLE; qclear(p); tpos[p] = 0;
    end else if (arm) begin
      mode[p] = M_ARMED; qclear(p); tpos[p] = 0;
    end else if (sample_valid && (mode[p] == M_ARMED || mode[p] == M_CAPTURE)) begin
      qpush(p, s);
      if (mode[p] == M_ARMED) begin
        if (trig) begin
          left[p] = post_of(p) - 1;
          mode[p] = M_CAPTURE;
        end
      end else begin
        left[p] = left[p] - 1;
      end
      if (mode[p] == M_CAPTURE && left[p] == 0) begin
        mode[p] = M_DONE;
        tpos[p] = qsize(p) - post_of(p);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] er [2];
    for (int p = 0; p < 2; p++) er[p] = reset ? 32'h0 : model_read(p, int'(rd_idx), rd_sel);
    for (int p = 0; p < 2; p++) model_step(p);
    @(posedge clk);
    #1;
    check("busy4", 32'(busy4), 32'(mode[0] == M_ARMED || mode[0] == M_CAPTURE));
    check("done4", 32'(done4), 32'(mode[0] == M_DONE));
    check("count4", 32'(count4), 32'(qsize(0)));
    check("tpos4", 32'(tpos4), 32'(tpos[0]));
    check("rd4", rd_data4, er[0]);
    check("busy1", 32'(busy1), 32'(mode[1] == M_ARMED || mode[1] == M_CAPTURE));
    check("done1", 32'(done1), 32'(mode[1] == M_DONE));
    check("count1", 32'(count1), 32'(qsize(1)));
    check("tpos1", 32'(tpos1), 32'(tpos[1]));
    check("rd1", rd_data1, er[1]);
  endtask

  task automatic quiet();
    reset = 0; arm = 0; sample_valid = 0; force_trig = 0;
  endtask

  task automatic put(input logic [31:0] pc);
    sample_valid = 1; pc_in = pc; instr_in = $urandom; result_in = $urandom;
    cycle();
    sample_valid = 0;
  endtask

  task automatic do_arm();
    arm = 1; cycle(); arm = 0;
  endtask

  initial begin
    reset = 1; arm = 0; sample_valid = 0; trig_pc_en = 0; force_trig = 0;
    pc_in = 0; instr_in = 0; result_in = 0; trig_pc = 0; rd_idx = 0; rd_sel = 0;
    for (int p = 0; p < 2; p++) begin mode[p] = M_IDLE; left[p] = 0; tpos[p] = 0; end
    cycle(); cycle();
    check("rst_count", 32'(count4), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_rd", rd_data4, 32'h0);
    quiet();

    // Trigger after three pre-trigger samples
    trig_pc_en = 1; trig_pc = 32'h0C;
    do_arm();
    for (int i = 0; i < 7; i++) put(32'(i * 4));
    cycle();
    check("s1_done", 32'(done4), 32'h1);
    check("s1_count", 32'(count4), 32'd7);
    check("s1_tpos", 32'(tpos4), 32'd3);
    rd_sel = 2'b00;
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      cycle();
      check("s1_rd", rd_data4, (i < 7) ? 32'(i * 4) : 32'h0);
    end

    // Wrap-around with 20 pre-trigger samples
    trig_pc = 32'h50;
    do_arm();
    for (int i = 0; i < 24; i++) put(32'(i * 4));
    check("s2_count", 32'(count4), 32'd8);
    check("s2_tpos", 32'(tpos4), 32'd4);
    rd_idx = 3'd0; cycle(); check("s2_rd0", rd_data4, 32'h40);
    rd_idx = 3'd4; cycle(); check("s2_rd4", rd_data4, 32'h50);
    rd_idx = 3'd7; cycle(); check("s2_rd7", rd_data4, 32'h5C);

    // POST=1 forced trigger on the first sample
    trig_pc_en = 0;
    do_arm();
    sample_valid = 1; force_trig = 1; pc_in = 32'h100; instr_in = 32'hE3A01005; result_in = 32'h5;
    cycle();
    quiet();
    check("s3_done", 32'(done1), 32'h1);
    check("s3_count", 32'(count1), 32'd1);
    check("s3_tpos", 32'(tpos1), 32'd0);
    rd_sel = 2'b01; rd_idx = 3'd0;
    cycle();
    check("s3_rd", rd_data1, 32'hE3A01005);

    // Gaps in sample_valid, and a match without sample_valid
    trig_pc_en = 1; trig_pc = 32'h100; rd_sel = 2'b00;
    do_arm();
    put(32'h10);
    pc_in = 32'h100; cycle();
    check("s4_nostore", 32'(count4), 32'd1);
    check("s4_notrig", 32'(busy4), 32'h1);
    put(32'h100); cycle(); put(32'h104); cycle(); put(32'h108); put(32'h10C);
    check("s4_done", 32'(done4), 32'h1);
    check("s4_count", 32'(count4), 32'd5);
    check("s4_tpos", 32'(tpos4), 32'd1);

    // arm with a valid matching sample while capturing
    trig_pc = 32'h200;
    do_arm();
    put(32'h200);
    arm = 1; sample_valid = 1; pc_in = 32'h200;
    cycle();
    quiet();
    check("s5_busy", 32'(busy4), 32'h1);
    check("s5_count", 32'(count4), 32'd0);
    check("s5_done", 32'(done4), 32'h0);

    // reset mid-capture, then samples are ignored
    put(32'h200); put(32'h204);
    rd_idx = 3'd0;
    reset = 1; arm = 1; sample_valid = 1;
    cycle();
    quiet();
    check("s6_busy", 32'(busy4), 32'h0);
    check("s6_done", 32'(done4), 32'h0);
    check("s6_count", 32'(count4), 32'd0);
    check("s6_rd", rd_data4, 32'h0);
    force_trig = 1;
    for (int i = 0; i < 3; i++) put(32'h200);
    force_trig = 0;
    check("s6_ignored", 32'(count4), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      arm          = ($urandom_range(0, 15) == 0);
      sample_valid = $urandom_range(0, 1) == 1;
      force_trig   = ($urandom_range(0, 19) == 0);
      trig_pc_en   = $urandom_range(0, 1) == 1;
      trig_pc      = 32'($urandom_range(0, 15) * 4);
      pc_in        = 32'($urandom_range(0, 15) * 4);
      instr_in     = $urandom;
      result_in    = $urandom;
      rd_idx       = 3'($urandom_range(0, 7));
      rd_sel       = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
